// File: rtl/dcim_acc_pkg.sv
// Shared types, default parameters and overflow detection for the
// partial-sum accumulation controller.
package dcim_acc_pkg;

    localparam int IN_W_DEF    = 12;
    localparam int ACC_W_DEF   = 20;
    localparam int MAX_LEN_DEF = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_e;

    // Overflow from a (W+1)-bit adder result: the carry out for unsigned
    // operands, disagreement of the two top bits for signed operands.
    function automatic logic ovf_detect(input logic sus,
                                        input logic sum_top,
                                        input logic sum_msb);
        return sus ? (sum_top ^ sum_msb) : sum_top;
    endfunction

endpackage

// File: rtl/add.sv
// WIDTH-bit adder with one extra result bit. With sus = 1 both operands are
// treated as two's complement and sign-extended; otherwise zero-extended.
module add #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sus,
    output logic [WIDTH:0]   sum
);

    logic a_ext;
    logic b_ext;

    // Extension bits select signed or unsigned interpretation.
    always_comb begin
        a_ext = sus & a[WIDTH-1];
        b_ext = sus & b[WIDTH-1];
        sum   = {a_ext, a} + {b_ext, b};
    end

endmodule

// File: rtl/psum_acc_ctrl.sv
// Accumulates a stream of IN_W-bit partial sums into one ACC_W-bit result per
// group using a single shared adder. Handshakes: a beat transfers on a cycle
// where in_valid && in_ready; a result transfers on a cycle where
// out_valid && out_ready. in_ready depends only on the controller state.
module psum_acc_ctrl
    import dcim_acc_pkg::*;
#(
    parameter int  IN_W    = IN_W_DEF,
    parameter int  ACC_W   = ACC_W_DEF,
    parameter int  MAX_LEN = MAX_LEN_DEF,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sus,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             out_trunc
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sus_q, sus_d;
    logic             ovf_q, ovf_d;
    logic             trunc_q, trunc_d;

    logic             sus_eff;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W:0]   add_sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt_next;

    // Operand selection: a new group starts from zero, mode is taken live
    // on the first beat and from the latched copy afterwards.
    always_comb begin
        sus_eff  = (state_q == IDLE) ? sus : sus_q;
        add_a    = (state_q == ACC) ? acc_q : '0;
        add_b    = {{(ACC_W-IN_W){sus_eff & in_data[IN_W-1]}}, in_data};
        cnt_next = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        ovf      = ovf_detect(sus_eff, add_sum[ACC_W], add_sum[ACC_W-1]);
    end

    add #(.WIDTH(ACC_W)) u_add (
        .a   (add_a),
        .b   (add_b),
        .sus (sus_eff),
        .sum (add_sum)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sus_d     = sus_q;
        ovf_d     = ovf_q;
        trunc_d   = trunc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d = add_sum[ACC_W-1:0];
                    cnt_d = cnt_next;
                    if (state_q == IDLE) begin
                        sus_d = sus;
                        ovf_d = ovf;
                    end else begin
                        ovf_d = ovf_q | ovf;
                    end
                    if (in_last || (cnt_next == CNT_W'(MAX_LEN))) begin
                        state_d = DONE;
                        trunc_d = ~in_last;
                    end else begin
                        state_d = ACC;
                        trunc_d = 1'b0;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any partial group.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sus_q   <= 1'b0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sus_q   <= sus_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;
    assign out_trunc = trunc_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Bench for psum_acc_ctrl: three instances (default, ACC_W=13/MAX_LEN=4,
// MAX_LEN=1) share one stimulus stream; a transaction-level model tracks
// each instance and is compared every cycle, alongside directed vectors.
module tb_psum_acc_ctrl;

    localparam int IN_W = 12;

    bit              clk;
    logic            rst;
    logic            sus;
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf, a_out_trunc;
    logic [19:0] a_out_sum;
    logic [8:0]  a_out_cnt;
    logic        b_in_ready, b_out_valid, b_out_ovf, b_out_trunc;
    logic [12:0] b_out_sum;
    logic [2:0]  b_out_cnt;
    logic        c_in_ready, c_out_valid, c_out_ovf, c_out_trunc;
    logic [19:0] c_out_sum;
    logic [0:0]  c_out_cnt;

    int n_cmp;
    int n_bad;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    psum_acc_ctrl #(.IN_W(12), .ACC_W(20), .MAX_LEN(256)) u_dut_a (
        .clk(clk), .rst(rst), .sus(sus), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf), .out_trunc(a_out_trunc)
    );

    psum_acc_ctrl #(.IN_W(12), .ACC_W(13), .MAX_LEN(4)) u_dut_b (
        .clk(clk), .rst(rst), .sus(sus), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf), .out_trunc(b_out_trunc)
    );

    psum_acc_ctrl #(.IN_W(12), .ACC_W(20), .MAX_LEN(1)) u_dut_c (
        .clk(clk), .rst(rst), .sus(sus), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_sum(c_out_sum), .out_cnt(c_out_cnt), .out_ovf(c_out_ovf), .out_trunc(c_out_trunc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Per instance: whether a finished result is waiting, the open group's
    // running value (wrapped to ACC_W), beat count, mode and sticky overflow.
    int     acc_w_m [3] = '{20, 13, 20};
    int     max_len_m [3] = '{256, 4, 1};
    bit     m_pend [3];
    bit     m_open [3];
    longint m_acc [3];
    int     m_cnt [3];
    bit     m_sus [3];
    bit     m_ovf [3];
    longint r_sum [3];
    int     r_cnt [3];
    bit     r_ovf [3];
    bit     r_trunc [3];
    longint mx, ma, mt, mfull;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_pend[i] = 1'b0;
                m_open[i] = 1'b0;
            end else if (m_pend[i]) begin
                if (out_ready) m_pend[i] = 1'b0;
            end else if (in_valid) begin
                if (!m_open[i]) begin
                    m_open[i] = 1'b1;
                    m_acc[i]  = 0;
                    m_cnt[i]  = 0;
                    m_sus[i]  = sus;
                    m_ovf[i]  = 1'b0;
                end
                mfull = longint'(1) << acc_w_m[i];
                if (m_sus[i]) begin
                    mx = in_data[IN_W-1] ? longint'(in_data) - (longint'(1) << IN_W) : longint'(in_data);
                    ma = (m_acc[i] >= mfull / 2) ? m_acc[i] - mfull : m_acc[i];
                    mt = ma + mx;
                    if (mt >= mfull / 2 || mt < -(mfull / 2)) m_ovf[i] = 1'b1;
                end else begin
                    mt = m_acc[i] + longint'(in_data);
                    if (mt >= mfull) m_ovf[i] = 1'b1;
                end
                m_acc[i] = ((mt % mfull) + mfull) % mfull;
                m_cnt[i] = m_cnt[i] + 1;
                if (in_last || m_cnt[i] == max_len_m[i]) begin
                    m_pend[i]  = 1'b1;
                    m_open[i]  = 1'b0;
                    r_sum[i]   = m_acc[i];
                    r_cnt[i]   = m_cnt[i];
                    r_ovf[i]   = m_ovf[i];
                    r_trunc[i] = !in_last;
                end
            end
        end
    end

    task automatic chk_inst(input int i, input string nm, input logic rdy, input logic vld,
                            input logic [31:0] s, input logic [31:0] c, input logic o, input logic t);
        chk($sformatf("%s_in_ready", nm), 32'(rdy), 32'(!m_pend[i]));
        chk($sformatf("%s_out_valid", nm), 32'(vld), 32'(m_pend[i]));
        if (m_pend[i]) begin
            chk($sformatf("%s_out_sum", nm), s, 32'(r_sum[i]));
            chk($sformatf("%s_out_cnt", nm), c, 32'(r_cnt[i]));
            chk($sformatf("%s_out_ovf", nm), 32'(o), 32'(r_ovf[i]));
            chk($sformatf("%s_out_trunc", nm), 32'(t), 32'(r_trunc[i]));
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        chk_inst(0, "mdl_a", a_in_ready, a_out_valid, 32'(a_out_sum), 32'(a_out_cnt), a_out_ovf, a_out_trunc);
        chk_inst(1, "mdl_b", b_in_ready, b_out_valid, 32'(b_out_sum), 32'(b_out_cnt), b_out_ovf, b_out_trunc);
        chk_inst(2, "mdl_c", c_in_ready, c_out_valid, 32'(c_out_sum), 32'(c_out_cnt), c_out_ovf, c_out_trunc);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [IN_W-1:0] d, input logic l);
        in_valid = v;
        sus      = s;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic flush();
        drive(1'b0, 1'b0, '0, 1'b0);
        out_ready = 1'b1;
        step();
        step();
    endtask

    task automatic chk_a(input string nm, input logic [19:0] s, input int c,
                         input logic o, input logic t);
        chk({nm, "_valid"}, 32'(a_out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(a_out_sum), 32'(s));
        chk({nm, "_cnt"}, 32'(a_out_cnt), 32'(c));
        chk({nm, "_ovf"}, 32'(a_out_ovf), 32'(o));
        chk({nm, "_trunc"}, 32'(a_out_trunc), 32'(t));
    endtask

    task automatic chk_b(input string nm, input logic [12:0] s, input int c,
                         input logic o, input logic t);
        chk({nm, "_valid"}, 32'(b_out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(b_out_sum), 32'(s));
        chk({nm, "_cnt"}, 32'(b_out_cnt), 32'(c));
        chk({nm, "_ovf"}, 32'(b_out_ovf), 32'(o));
        chk({nm, "_trunc"}, 32'(b_out_trunc), 32'(t));
    endtask

    typedef struct {
        logic        sus;
        logic [11:0] data;
        logic        last;
        logic [19:0] exp_sum;
        int          exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{1'b0, 12'd100,  1'b0, 20'h0,     0, 1'b0};
        tbl[1] = '{1'b0, 12'd200,  1'b0, 20'h0,     0, 1'b0};
        tbl[2] = '{1'b0, 12'd300,  1'b1, 20'd600,   3, 1'b0};
        tbl[3] = '{1'b1, 12'hFFB,  1'b0, 20'h0,     0, 1'b0};
        tbl[4] = '{1'b0, 12'h003,  1'b1, 20'hFFFFE, 2, 1'b0};
        tbl[5] = '{1'b0, 12'hFFF,  1'b1, 20'h00FFF, 1, 1'b0};
        tbl[6] = '{1'b1, 12'h800,  1'b0, 20'h0,     0, 1'b0};
        tbl[7] = '{1'b1, 12'h800,  1'b1, 20'hFF000, 2, 1'b0};

        // ---- reset ----
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        step();
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_sum", 32'(a_out_sum), 32'd0);
        chk("rst_out_cnt", 32'(a_out_cnt), 32'd0);
        chk("rst_out_ovf", 32'(a_out_ovf), 32'd0);
        chk("rst_out_trunc", 32'(a_out_trunc), 32'd0);
        rst = 1'b0;
        step();

        // ---- table vectors on the default instance ----
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, tbl[k].sus, tbl[k].data, tbl[k].last);
            step();
            if (tbl[k].last) begin
                chk_a($sformatf("tbl%0d", k), tbl[k].exp_sum, tbl[k].exp_cnt, tbl[k].exp_ovf, 1'b0);
                drive(1'b0, 1'b0, '0, 1'b0);
                step();
            end
        end

        // ---- backpressure: result held while out_ready is low ----
        flush();
        drive(1'b1, 1'b0, 12'd5, 1'b0);
        step();
        drive(1'b1, 1'b0, 12'd6, 1'b1);
        out_ready = 1'b0;
        step();
        drive(1'b1, 1'b0, 12'd99, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_in_ready", k), 32'(a_in_ready), 32'd0);
            chk_a($sformatf("bp%0d", k), 20'd11, 2, 1'b0, 1'b0);
            step();
        end
        out_ready = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_a("bp_release", 20'd11, 2, 1'b0, 1'b0);
        step();
        chk("bp_after_valid", 32'(a_out_valid), 32'd0);
        chk("bp_after_ready", 32'(a_in_ready), 32'd1);

        // ---- 13-bit overflow, unsigned then signed ----
        flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 12'hFFF, k == 2);
            step();
        end
        chk_b("ovf_u", 13'h0FFD, 3, 1'b1, 1'b0);
        flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 12'h7FF, k == 2);
            step();
        end
        chk_b("ovf_s", 13'h17FD, 3, 1'b1, 1'b0);

        // ---- truncation at MAX_LEN=4, fifth beat opens next group ----
        flush();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 12'd1, 1'b0);
            step();
        end
        chk_b("trunc", 13'd4, 4, 1'b0, 1'b1);
        step();
        step();
        drive(1'b1, 1'b0, 12'd0, 1'b1);
        step();
        chk_b("trunc_next", 13'd1, 2, 1'b0, 1'b0);

        // ---- reset in the middle of a group ----
        flush();
        drive(1'b1, 1'b0, 12'd50, 1'b0);
        step();
        step();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        step();
        chk("mrst_in_ready", 32'(a_in_ready), 32'd1);
        chk("mrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("mrst_out_cnt", 32'(a_out_cnt), 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 12'd7, 1'b1);
        step();
        chk_a("mrst_next", 20'd7, 1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
        step();

        // ---- randomized traffic checked by the model ----
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 4095)), $urandom_range(0, 5) == 0);
            out_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 1'b0;
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_acc_ctrl.md
# psum_acc_ctrl

Sequencing controller that time-shares one `add` instance (width = ACC_W) to accumulate a variable-length stream of IN_W-bit DCIM partial sums into one ACC_W-bit result per group. It sits between the macro's partial-sum output stage and the result/write-back logic. It owns valid/ready handshakes on both sides, latches the signed/unsigned mode per group, counts beats, and flags overflow and forced truncation.

## Interface
- IN_W, 12, partial-sum input width
- ACC_W, 20, accumulator and result width; ACC_W > IN_W
- MAX_LEN, 256, maximum beats per group; groups reaching MAX_LEN are force-closed
- CNT_W, $clog2(MAX_LEN+1), beat-count width (derived, not overridden)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sus  in  1  1 = signed accumulation, 0 = unsigned; sampled on a group's first beat
- in_valid  in  1  input beat valid
- in_ready  out  1  controller accepts a beat this cycle
- in_data  in  IN_W  partial sum
- in_last  in  1  final beat of the group
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_W  accumulated result (two's complement when signed)
- out_cnt  out  CNT_W  beats accumulated in the group
- out_ovf  out  1  sticky overflow seen during the group
- out_trunc  out  1  group closed by MAX_LEN, not by in_last

## Operation
- The controller has three states.
  - IDLE: in_ready = 1 and out_valid = 0.
  - ACC: in_ready = 1 and out_valid = 0.
  - DONE: in_ready = 0 and out_valid = 1.
- A beat is accepted when in_valid && in_ready.
- Mode: sus_eff = sus in IDLE; otherwise sus_eff = sus_q, the value latched on the first beat. Changes to sus after the first beat are ignored until the next group.
- Operand extension to ACC_W:
  - in_data is sign-extended when sus_eff = 1.
  - in_data is zero-extended when sus_eff = 0.
- Adder inputs:
  - a = 0 in IDLE, acc in ACC.
  - b = the extended in_data.
  - The adder's sus input is sus_eff.
- On each accepted beat:
  - acc <= sum[ACC_W-1:0].
  - cnt <= cnt + 1 (cnt restarts at 1 on a first beat).
  - ovf_q <= ovf_q | ovf. On a first beat, ovf_q <= ovf, which is always 0.
- Overflow bit:
  - Unsigned: ovf = sum[ACC_W].
  - Signed: ovf = sum[ACC_W] ^ sum[ACC_W-1].
  - On overflow the accumulator wraps modulo 2^ACC_W; it does not saturate.
- Transitions:
  - IDLE → ACC on an accepted beat with in_last = 0.
  - IDLE → DONE on an accepted beat with in_last = 1 (single-beat group).
  - ACC → DONE on an accepted beat with in_last = 1.
  - ACC → DONE on an accepted beat that makes cnt = MAX_LEN; out_trunc = 1 unless in_last is also 1.
  - DONE → IDLE when out_valid && out_ready.
- In DONE, out_sum, out_cnt, out_ovf and out_trunc are registered and held stable until the handshake completes.
- Reset mid-group discards the partial accumulation; no output is produced for that group.

## Timing
- Reset values: the state is IDLE, and acc, cnt, sus_q, ovf_q and trunc_q are 0. Outputs after reset:
  - in_ready = 1.
  - out_valid = 0.
  - out_sum, out_cnt, out_ovf and out_trunc are all 0.
- The accumulator update occurs in the same cycle the beat is accepted; the adder sits on a single combinational path.
- out_valid asserts the cycle after the closing beat is accepted.
- A group of N beats, with in_valid held high and out_ready = 1, occupies N + 1 cycles.
- The next group's first beat can be accepted the cycle after the output handshake completes.
- in_ready is a function of state only; it has no combinational path from out_ready or in_valid.
- MAX_LEN = 1 is legal: every group closes after one beat.

## Structure
- Package `dcim_acc_pkg` holds:
  - the state enum {IDLE, ACC, DONE};
  - the default parameter constants;
  - the overflow-detect function.
- One sub-module: the existing `add` instantiated as `u_add` with width = ACC_W.
- The FSM, counter and output registers live in psum_acc_ctrl.

## Test plan
- Unsigned sum: sus=0, beats 100, 200, 300 (last) → out_sum = 600, out_cnt = 3, out_ovf = 0, out_trunc = 0; out_valid asserts one cycle after the third beat.
- Signed sum: sus=1, beats 0xFFB (-5), 0x003 (last) → out_sum = 0xFFFFE (-2), out_cnt = 2. A sus toggle to 0 on beat 2 must not change this result.
- Overflow with ACC_W=13:
  - Unsigned beats 0xFFF ×3 → out_sum = 0x0FFD, out_ovf = 1.
  - Signed beats 0x7FF ×3 → out_sum = 0x17FD, out_ovf = 1.
- Truncation with MAX_LEN=4: five beats of 1 with in_last = 0 → first result is out_sum = 4, out_cnt = 4, out_trunc = 1. The fifth beat opens a new group with cnt = 1.
- Backpressure: out_ready held at 0 for 3 cycles in DONE → in_ready = 0 and outputs stable throughout; out_valid falls the cycle after out_ready = 1.
- Reset mid-group: after 2 accepted beats, rst pulses for 1 cycle → IDLE, out_valid = 0, in_ready = 1. The next single beat 7 (last) → out_sum = 7, out_cnt = 1.
